btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner_if.sv | 22 ++
 rtl/btn_conditioner.sv | 97 +++++++++
 tb/tb_btn_conditioner.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Push-button conditioner bundle: three raw active-low buttons in, three
// conditioned active-low requests out (to the Johnson counter).
//   master : drives the raw buttons, observes the conditioned requests
//   slave  : the conditioner itself
interface btn_conditioner_if;
    logic btn_left_n;
    logic btn_right_n;
    logic btn_stop_n;
    logic goLeft;
    logic goRight;
    logic stop;

    modport master (
        output btn_left_n, btn_right_n, btn_stop_n,
        input  goLeft, goRight, stop
    );

    modport slave (
        input  btn_left_n, btn_right_n, btn_stop_n,
        output goLeft, goRight, stop
    );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes and debounces three independent active-low
// push-buttons (left, right, stop) into registered active-low requests.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset (all state -> released / 0)
//   bus  - btn_conditioner_if.slave: btn_*_n raw inputs, goLeft/goRight/stop
//
// Parameter:
//   DEBOUNCE_CYCLES (2..255) - consecutive clocks a synchronized input must
//   disagree with the stable state before the stable state flips.
//
// Optional feature (macro BTN_PRESS_PULSE_EN):
//   undefined - output follows the debounced level (low for the whole press)
//   defined   - output is a single-clock low pulse on each debounced press;
//               held presses and releases leave it high.

// One conditioning channel: 2-flop synchronizer, saturating debounce counter,
// stable state and the registered output.
module btn_chan #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic out_n
);
    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1, sync2, stable;
    logic [7:0] cnt;
    logic       differ, flip, stable_nxt;

    assign differ     = (sync2 != stable);
    // Counter only advances while it is below LAST, so reaching LAST with
    // the input still disagreeing means DEBOUNCE_CYCLES in a row.
    assign flip       = differ && (cnt == LAST);
    assign stable_nxt = stable ^ flip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= 8'd0;
            out_n  <= 1'b1;
        end else begin
            sync1  <= btn_n;
            sync2  <= sync1;
            // Any agreement, or the flip itself, restarts the count.
            if (!differ || flip)
                cnt <= 8'd0;
            else
                cnt <= cnt + 8'd1;
            stable <= stable_nxt;
`ifdef BTN_PRESS_PULSE_EN
            // Low only on the 1->0 flip of the stable state.
            out_n  <= ~(flip & stable);
`else
            // Output updates on the same edge as the stable state.
            out_n  <= stable_nxt;
`endif
        end
    end
endmodule

module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    btn_conditioner_if.slave  bus
);
    localparam int NUM_CH = 3;

    // Channel order: 0 = left, 1 = right, 2 = stop.
    logic [NUM_CH-1:0] raw_n;
    logic [NUM_CH-1:0] cond_n;

    assign raw_n = {bus.btn_stop_n, bus.btn_right_n, bus.btn_left_n};

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            btn_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
                .clk   (clk),
                .rst   (rst),
                .btn_n (raw_n[g]),
                .out_n (cond_n[g])
            );
        end
    endgenerate

    assign bus.goLeft  = cond_n[0];
    assign bus.goRight = cond_n[1];
    assign bus.stop    = cond_n[2];
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner (DEBOUNCE_CYCLES=4). A window-based model says
// a channel's stable state flips when the last DEBOUNCE_CYCLES synchronized
// samples (raw delayed by two clocks) all disagree with it; that model is
// compared every cycle, and directed scenarios pin edge-exact expectations.
// Build with +define+BTN_PRESS_PULSE_EN to exercise pulse mode.
module tb_btn_conditioner;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    btn_conditioner_if bus ();

    btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[c][0] = raw sampled at this edge, hist[c][k] = k edges earlier.
    logic [2:0][D+1:0] hist;
    logic [2:0]        m_stable;
    logic [2:0]        m_out;

    initial begin
        logic [2:0]   raw;
        logic [D-1:0] win;
        logic         flipped;
        hist     = '1;
        m_stable = '1;
        m_out    = '1;
        forever begin
            @(posedge clk);
            raw = {bus.btn_stop_n, bus.btn_right_n, bus.btn_left_n};
            for (int c = 0; c < 3; c++) begin
                if (rst) begin
                    hist[c]     = '1;
                    m_stable[c] = 1'b1;
                    m_out[c]    = 1'b1;
                end else begin
                    hist[c] = {hist[c][D:0], raw[c]};
                    win     = hist[c][D+1:2];
                    flipped = (win == {D{~m_stable[c]}});
                    if (flipped) m_stable[c] = ~m_stable[c];
`ifdef BTN_PRESS_PULSE_EN
                    m_out[c] = !(flipped && !m_stable[c]);
`else
                    m_out[c] = m_stable[c];
`endif
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("model_goLeft",  bus.goLeft,  m_out[0]);
            chk("model_goRight", bus.goRight, m_out[1]);
            chk("model_stop",    bus.stop,    m_out[2]);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int lows;
        bus.btn_left_n  = 1'b1;
        bus.btn_right_n = 1'b1;
        bus.btn_stop_n  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_goLeft",  bus.goLeft,  1'b1);
        chk("rst_goRight", bus.goRight, 1'b1);
        chk("rst_stop",    bus.stop,    1'b1);
        @(negedge clk); rst = 1'b0;
        idle(3);

        // Right held 20 clocks: low from edge 5 until 5 edges after release
        bus.btn_right_n = 1'b0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (e == 4)  chk("A_e4",  bus.goRight, 1'b1);
            if (e == 5)  chk("A_e5",  bus.goRight, 1'b0);
`ifdef BTN_PRESS_PULSE_EN
            if (e == 6)  chk("A_e6",  bus.goRight, 1'b1);
            if (e == 24) chk("A_e24", bus.goRight, 1'b1);
`else
            if (e == 6)  chk("A_e6",  bus.goRight, 1'b0);
            if (e == 24) chk("A_e24", bus.goRight, 1'b0);
`endif
            if (e == 25) chk("A_e25", bus.goRight, 1'b1);
            @(negedge clk);
            if (e == 19) bus.btn_right_n = 1'b1;
        end
        idle(5);

        // Left bounce 3 low / 2 high / 3 low: never accepted
        bus.btn_left_n = 1'b0;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #1;
            chk($sformatf("B_e%0d", e), bus.goLeft, 1'b1);
            @(negedge clk);
            if (e == 2) bus.btn_left_n = 1'b1;
            if (e == 4) bus.btn_left_n = 1'b0;
            if (e == 7) bus.btn_left_n = 1'b1;
        end
        idle(5);

        // Shortest accepted press: exactly D clocks low
        bus.btn_right_n = 1'b0;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk); #1;
            if (e == 4) chk("C_e4", bus.goRight, 1'b1);
            if (e == 5) chk("C_e5", bus.goRight, 1'b0);
`ifndef BTN_PRESS_PULSE_EN
            if (e == 8) chk("C_e8", bus.goRight, 1'b0);
`endif
            if (e == 9) chk("C_e9", bus.goRight, 1'b1);
            @(negedge clk);
            if (e == D - 1) bus.btn_right_n = 1'b1;
        end
        idle(5);

        // Stop held 50 clocks: count low cycles over press and release
        bus.btn_stop_n = 1'b0;
        lows = 0;
        for (int e = 0; e < 62; e++) begin
            @(posedge clk); #1;
            if (bus.stop == 1'b0) lows++;
            if (e == 5) chk("D_e5", bus.stop, 1'b0);
            @(negedge clk);
            if (e == 49) bus.btn_stop_n = 1'b1;
        end
`ifdef BTN_PRESS_PULSE_EN
        chk_int("D_low_cycles", lows, 1);
`else
        chk_int("D_low_cycles", lows, 50);
`endif
        idle(5);

        // Left + stop together; right untouched
        bus.btn_left_n = 1'b0;
        bus.btn_stop_n = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (e == 4) begin
                chk("E_e4_left", bus.goLeft, 1'b1);
                chk("E_e4_stop", bus.stop,   1'b1);
            end
            if (e == 5) begin
                chk("E_e5_left",  bus.goLeft,  1'b0);
                chk("E_e5_stop",  bus.stop,    1'b0);
                chk("E_e5_right", bus.goRight, 1'b1);
            end
            @(negedge clk);
            if (e == 9) begin
                bus.btn_left_n = 1'b1;
                bus.btn_stop_n = 1'b1;
            end
        end
        idle(5);

        // Reset mid-debounce with right held: full latency again after release
        bus.btn_right_n = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            chk("F_pre", bus.goRight, 1'b1);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("F_rst_goLeft",  bus.goLeft,  1'b1);
        chk("F_rst_goRight", bus.goRight, 1'b1);
        chk("F_rst_stop",    bus.stop,    1'b1);
        @(negedge clk); rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == D + 1) chk("F_k5", bus.goRight, 1'b1);
            if (k == D + 2) chk("F_k6", bus.goRight, 1'b0);
            @(negedge clk);
        end
        bus.btn_right_n = 1'b1;
        idle(10);

        // Random bounce on all channels, with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) bus.btn_left_n  = ~bus.btn_left_n;
            if ($urandom_range(0, 5) == 0) bus.btn_right_n = ~bus.btn_right_n;
            if ($urandom_range(0, 5) == 0) bus.btn_stop_n  = ~bus.btn_stop_n;
            if (i == 200) rst = 1'b1;
            if (i == 202) rst = 1'b0;
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
